// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates the unified single-port memory between the fetch port and the data port.
// Latency : grant at N, mem_req at N+1, ack 1 cycle after mem_ack; out-of-range requests ack at N+1.
// Backpr. : requesters hold req until their ack pulse; f_stall/m_stall flag each port that is still waiting.
// Ports   : f_* fetch port (80-bit instruction window), m_* data port (64-bit word),
//           mem_* registered handshake to the memory model, clk/rst_n (async active-low).
module mem_port_arbiter #(
  parameter int ADDR_LIMIT = 1024,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_ack,
  output logic [79:0] f_rdata,
  output logic        f_err,
  output logic        f_stall,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic        m_ack,
  output logic [63:0] m_rdata,
  output logic        m_err,
  output logic        m_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [79:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, F_BUSY, M_BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;

  logic        f_ack_d, f_err_d, m_ack_d, m_err_d;
  logic [79:0] f_rdata_d;
  logic [63:0] m_rdata_d;
  logic        mem_req_d, mem_we_d;
  logic [63:0] mem_addr_d, mem_wdata_d;

  // 65-bit end addresses so that a request wrapping past 2^64 is caught as out of range.
  logic [64:0] f_end, m_end;
  logic        f_oob, m_oob, m_wins, timed_out;

  assign f_end     = {1'b0, f_addr} + 65'd10;
  assign m_end     = {1'b0, m_addr} + 65'd8;
  assign f_oob     = f_end > 65'(ADDR_LIMIT);
  assign m_oob     = m_end > 65'(ADDR_LIMIT);
  assign m_wins    = m_req && !(f_req && starve_q == SW'(STARVE_MAX));
  assign timed_out = wait_q == WW'(TIMEOUT - 1);

  assign f_stall = f_req & ~f_ack;
  assign m_stall = m_req & ~m_ack;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    f_ack_d     = 1'b0;
    m_ack_d     = 1'b0;
    f_err_d     = f_err;
    m_err_d     = m_err;
    f_rdata_d   = f_rdata;
    m_rdata_d   = m_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    unique case (state_q)
      IDLE: begin
        if (m_wins) begin
          // Fetch can only lose while below the limit, so this increment saturates by construction.
          if (f_req) starve_d = starve_q + SW'(1);
          if (m_oob) begin
            m_ack_d   = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
            state_d   = RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = m_we;
            mem_addr_d  = m_addr;
            mem_wdata_d = m_wdata;
            wait_d      = '0;
            state_d     = M_BUSY;
          end
        end else if (f_req) begin
          starve_d = '0;
          if (f_oob) begin
            f_ack_d   = 1'b1;
            f_err_d   = 1'b1;
            f_rdata_d = '0;
            state_d   = RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
            wait_d      = '0;
            state_d     = F_BUSY;
          end
        end
      end

      F_BUSY: begin
        // A late ack landing on the timeout cycle still counts as success.
        if (mem_ack) begin
          f_ack_d   = 1'b1;
          f_err_d   = 1'b0;
          f_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else if (timed_out) begin
          f_ack_d   = 1'b1;
          f_err_d   = 1'b1;
          f_rdata_d = '0;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      M_BUSY: begin
        if (mem_ack) begin
          m_ack_d   = 1'b1;
          m_err_d   = 1'b0;
          m_rdata_d = mem_we ? 64'd0 : mem_rdata[63:0];
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else if (timed_out) begin
          m_ack_d   = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      // Ack cycle: requests are deliberately not sampled so a still-held request is not re-served.
      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      wait_q    <= '0;
      f_ack     <= 1'b0;
      f_err     <= 1'b0;
      f_rdata   <= '0;
      m_ack     <= 1'b0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
      f_ack     <= f_ack_d;
      f_err     <= f_err_d;
      f_rdata   <= f_rdata_d;
      m_ack     <= m_ack_d;
      m_err     <= m_err_d;
      m_rdata   <= m_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter against a transaction-level reference.
// Latency : derives expected ack cycles from the grant/timeout timing rules.
// Backpr. : requests are held until the matching ack, then dropped.
module tb_mem_port_arbiter;

  localparam int ADDR_LIMIT = 1024;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;
  localparam int NEVER      = 1000;

  logic        clk, rst_n;
  logic        f_req, f_ack, f_err, f_stall;
  logic [63:0] f_addr;
  logic [79:0] f_rdata;
  logic        m_req, m_we, m_ack, m_err, m_stall;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata;
  logic [79:0] mem_rdata;

  mem_port_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err), .f_stall(f_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .m_err(m_err), .m_stall(m_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment memory (answers the DUT) and reference memory (predicts results).
  logic [7:0]  env_mem [ADDR_LIMIT];
  logic [7:0]  ref_mem [ADDR_LIMIT];
  int          cur_lat = 0;
  int          resp_cnt = 0;
  int          model_losses = 0;
  logic [79:0] last_fr = '0;
  logic [63:0] last_mr = '0;
  logic        last_fe = 1'b0, last_me = 1'b0;
  logic [79:0] pat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [79:0] env_read(input logic [63:0] a);
    logic [79:0] r;
    logic [64:0] idx;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      idx = {1'b0, a} + 65'(i);
      if (idx < 65'(ADDR_LIMIT)) r[8*i +: 8] = env_mem[idx[9:0]];
    end
    return r;
  endfunction

  function automatic logic [79:0] ref_read(input logic [63:0] a);
    logic [79:0] r;
    logic [64:0] idx;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      idx = {1'b0, a} + 65'(i);
      if (idx < 65'(ADDR_LIMIT)) r[8*i +: 8] = ref_mem[idx[9:0]];
    end
    return r;
  endfunction

  // Memory responder: acks cur_lat cycles after mem_req first appears, junk data otherwise.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && resp_cnt == cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = env_read(mem_addr);
        if (mem_we)
          for (int i = 0; i < 8; i++) env_mem[mem_addr[9:0] + 10'(i)] = mem_wdata[8*i +: 8];
        resp_cnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = {16'($urandom), $urandom, $urandom};
        resp_cnt  = mem_req ? resp_cnt + 1 : 0;
      end
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pick_addr(input int span);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
    if (r == 1) return 64'(ADDR_LIMIT - span + $urandom_range(1, span));
    if (r == 2) return 64'(ADDR_LIMIT - span);
    return 64'($urandom_range(0, ADDR_LIMIT - span));
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 7);
    if (r <= 3) return r;
    if (r == 4) return TIMEOUT - 1;
    if (r == 5) return NEVER;
    return 0;
  endfunction

  // One transaction round: either or both ports request; checks ack timing, data, errors and mem side.
  task automatic run_txn(input bit do_f, input logic [63:0] fa, input int lf,
                         input bit do_m, input bit we, input logic [63:0] ma,
                         input logic [63:0] md, input int lm);
    bit f_oob, m_oob, f_ok, m_ok, m_first, got_f, got_m, serving_m;
    int dur_f, dur_m, exp_fc, exp_mc;
    logic [79:0] exp_fr, tmp;
    logic [63:0] exp_mr;
    f_oob = ({1'b0, fa} + 65'd10) > 65'(ADDR_LIMIT);
    m_oob = ({1'b0, ma} + 65'd8) > 65'(ADDR_LIMIT);
    f_ok  = !f_oob && lf < TIMEOUT;
    m_ok  = !m_oob && lm < TIMEOUT;
    dur_f = f_oob ? 1 : (f_ok ? lf + 2 : TIMEOUT + 1);
    dur_m = m_oob ? 1 : (m_ok ? lm + 2 : TIMEOUT + 1);
    m_first = do_m && !(do_f && model_losses == STARVE_MAX);
    if (do_f && do_m) begin
      exp_mc = m_first ? dur_m : dur_f + 1 + dur_m;
      exp_fc = m_first ? dur_m + 1 + dur_f : dur_f;
    end else begin
      exp_fc = dur_f;
      exp_mc = dur_m;
    end
    if (do_f) model_losses = 0;
    tmp    = ref_read(ma);
    exp_mr = (m_ok && !we) ? tmp[63:0] : 64'd0;
    if (m_first && do_m && we && m_ok)
      for (int i = 0; i < 8; i++) ref_mem[ma[9:0] + 10'(i)] = md[8*i +: 8];
    exp_fr = f_ok ? ref_read(fa) : 80'd0;
    if (!m_first && do_m && we && m_ok)
      for (int i = 0; i < 8; i++) ref_mem[ma[9:0] + 10'(i)] = md[8*i +: 8];

    @(negedge clk);
    f_req = do_f; f_addr = fa;
    m_req = do_m; m_we = we; m_addr = ma; m_wdata = md;
    cur_lat = m_first ? lm : lf;
    #1;
    check("f_stall_req", f_stall, do_f);
    check("m_stall_req", m_stall, do_m);
    got_f = !do_f;
    got_m = !do_m;
    for (int c = 1; c <= 64 && !(got_f && got_m); c++) begin
      @(negedge clk);
      serving_m = do_m && (m_first ? !got_m : got_f);
      if (mem_req) begin
        check("mem_req_oob", serving_m ? m_oob : f_oob, 1'b0);
        check("mem_addr", mem_addr, serving_m ? ma : fa);
        check("mem_we", mem_we, serving_m ? we : 1'b0);
        if (serving_m && we) check("mem_wdata", mem_wdata, md);
      end
      if (do_f && c <= exp_fc) check("f_stall", f_stall, c < exp_fc);
      if (do_m && c <= exp_mc) check("m_stall", m_stall, c < exp_mc);
      if (f_ack) begin
        check("f_ack_spurious", got_f, 1'b0);
        check("f_ack_cycle", c, exp_fc);
        check("f_err", f_err, !f_ok);
        check("f_rdata", f_rdata, exp_fr);
        check("ack_overlap", m_ack, 1'b0);
        check("m_rdata_hold", m_rdata, last_mr);
        check("m_err_hold", m_err, last_me);
        last_fr = exp_fr; last_fe = !f_ok;
        got_f = 1'b1; f_req = 1'b0;
        if (!got_m) cur_lat = lm;
      end
      if (m_ack) begin
        check("m_ack_spurious", got_m, 1'b0);
        check("m_ack_cycle", c, exp_mc);
        check("m_err", m_err, !m_ok);
        check("m_rdata", m_rdata, exp_mr);
        check("f_rdata_hold", f_rdata, last_fr);
        check("f_err_hold", f_err, last_fe);
        last_mr = exp_mr; last_me = !m_ok;
        got_m = 1'b1; m_req = 1'b0;
        if (!got_f) cur_lat = lf;
      end
    end
    check("txn_done", got_f && got_m, 1'b1);
  endtask

  initial begin
    bit saw, seen, exp_m;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    pat = 80'h0123456789ABCDEF3030;
    for (int i = 0; i < ADDR_LIMIT; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    for (int i = 0; i < 10; i++) begin
      env_mem[32 + i] = pat[8*i +: 8];
      ref_mem[32 + i] = pat[8*i +: 8];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_f_ack", f_ack, 1'b0);
    check("rst_m_ack", m_ack, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_f_rdata", f_rdata, 80'd0);
    check("idle_m_rdata", m_rdata, 80'd0);
    check("idle_errs", {f_err, m_err}, 2'b00);
    check("idle_mem_bus", {mem_we, mem_addr, mem_wdata}, 129'd0);
    check("idle_stalls", {f_stall, m_stall}, 2'b00);

    // Fetch alone, zero-wait memory
    run_txn(1'b1, 64'h20, 0, 1'b0, 1'b0, 64'h0, 64'h0, 0);
    check("tp1_pattern", f_rdata, pat);

    // Data write, memory answers after 3 cycles
    run_txn(1'b0, 64'h0, 0, 1'b1, 1'b1, 64'h100, 64'hDEAD, 3);

    // Both ports held continuously: fetch forced in after STARVE_MAX losses
    @(negedge clk);
    f_req = 1'b1; f_addr = 64'h40; m_req = 1'b1; m_we = 1'b0; m_addr = 64'h80; cur_lat = 0;
    for (int g = 0; g < 11; g++) begin
      exp_m = (model_losses != STARVE_MAX);
      model_losses = exp_m ? model_losses + 1 : 0;
      seen = 1'b0;
      for (int c = 1; c <= 8 && !seen; c++) begin
        @(negedge clk);
        if (f_ack || m_ack) begin
          seen = 1'b1;
          check("grant_m", m_ack, exp_m);
          check("grant_f", f_ack, !exp_m);
          check("grant_gap", c, (g == 0) ? 2 : 3);
        end
      end
      check("grant_seen", seen, 1'b1);
    end
    f_req = 1'b0; m_req = 1'b0;
    last_fr = ref_read(64'h40); last_fe = 1'b0;
    pat = ref_read(64'h80); last_mr = pat[63:0]; last_me = 1'b0;

    // Out-of-range requests, including 64-bit wrap
    run_txn(1'b1, 64'd1020, 0, 1'b0, 1'b0, 64'h0, 64'h0, 0);
    run_txn(1'b0, 64'h0, 0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0);

    // Timeout, then a normal read of the earlier write
    run_txn(1'b0, 64'h0, 0, 1'b1, 1'b0, 64'h180, 64'h0, NEVER);
    run_txn(1'b0, 64'h0, 0, 1'b1, 1'b0, 64'h100, 64'h0, 0);

    // Reset in the middle of a data access
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h40; cur_lat = NEVER;
    repeat (3) @(negedge clk);
    check("busy_mem_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 1'b0);
    check("arst_m_ack", m_ack, 1'b0);
    check("arst_f_rdata", f_rdata, 80'd0);
    check("arst_m_rdata", m_rdata, 80'd0);
    m_req = 1'b0;
    model_losses = 0; last_fr = '0; last_mr = '0; last_fe = 1'b0; last_me = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_ack || f_ack || mem_req) saw = 1'b1;
    end
    check("no_ack_after_rst", saw, 1'b0);
    run_txn(1'b0, 64'h0, 0, 1'b1, 1'b0, 64'h40, 64'h0, 1);

    // Randomized rounds against the reference model
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, pick_addr(10), pick_lat(),
              kind != 0, 1'($urandom_range(0, 1)), pick_addr(8),
              {$urandom, $urandom}, pick_lat());
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the fetch stage (instruction read) and the memory stage (data read/write).
- Sequences each access with a registered handshake toward the memory.
- Checks bounds, reports timeouts, and generates per-stage stall signals for the pipeline control logic.
- Sits between fetch/memory stages and the memory model.

Parameters:
- ADDR_LIMIT, 1024, memory size in bytes; an access must lie entirely below this.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win.
- TIMEOUT, 15, cycles waiting for mem_ack before the access is aborted with error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch read request, level, held until f_ack
- f_addr  in  64  fetch byte address (10-byte instruction window)
- f_ack  out  1  one-cycle pulse: fetch access complete
- f_rdata  out  80  instruction bytes, little-endian from f_addr
- f_err  out  1  valid with f_ack: out-of-range or timeout
- f_stall  out  1  f_req & ~f_ack (combinational)
- m_req  in  1  data request, level, held until m_ack
- m_we  in  1  1 = write, 0 = read
- m_addr  in  64  data byte address (8-byte word)
- m_wdata  in  64  write data
- m_ack  out  1  one-cycle pulse: data access complete
- m_rdata  out  64  read data
- m_err  out  1  valid with m_ack
- m_stall  out  1  m_req & ~m_ack (combinational)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  64  memory address
- mem_wdata  out  64  memory write data
- mem_ack  in  1  memory completion, single cycle
- mem_rdata  in  80  memory read data, valid with mem_ack

Behaviour:
- Reset values:
  - state IDLE; starve_cnt = 0; wait_cnt = 0.
  - All outputs 0, including rdata buses.
  - Reset mid-access drops mem_req immediately; no ack is issued for the aborted access.
- All outputs are registered except f_stall and m_stall.
- FSM states: IDLE, F_BUSY, M_BUSY, RESP.
- IDLE, arbitration:
  - If m_req and not (f_req and starve_cnt == STARVE_MAX), the data port wins.
  - Else if f_req, fetch wins.
  - starve_cnt increments, saturating at STARVE_MAX, when f_req loses. It clears when fetch wins.
- IDLE, bounds check on the winner:
  - Fetch is out of range if f_addr + 10 > ADDR_LIMIT.
  - Data is out of range if m_addr + 8 > ADDR_LIMIT.
  - Use 65-bit arithmetic, so address wrap-around counts as out of range.
  - Out of range: go to RESP with err = 1 and rdata = 0. No memory access is made.
- IDLE, in-range grant:
  - Register mem_req = 1 together with mem_addr, mem_we (0 for fetch), and mem_wdata.
  - Go to F_BUSY or M_BUSY; wait_cnt = 0.
- F_BUSY / M_BUSY:
  - mem_req and mem_* are held stable.
  - On mem_ack, capture rdata: f_rdata = mem_rdata, or m_rdata = mem_rdata[63:0] for reads and 0 for writes. Set mem_req = 0 and go to RESP with err = 0.
  - Otherwise wait_cnt increments. When wait_cnt reaches TIMEOUT-1 with no mem_ack, set mem_req = 0, rdata = 0, err = 1, and go to RESP.
  - An ack arriving on the same cycle as the timeout takes precedence (success).
- RESP:
  - The granted requester's ack is 1 for exactly this cycle, with err and rdata valid.
  - The next state is always IDLE.
  - Requests are not sampled in RESP, so a request still held during its ack cycle is never served twice.
  - Requesters drop or replace their request in the cycle after ack.
- Latency: request seen in IDLE at cycle N; mem_req visible at N+1; mem_ack at N+1 gives ack at N+2. Next arbitration at N+3.
- Error responses: request at N gives ack+err at N+1.
- rdata and err hold their value until the next ack to the same port.
- The non-granted port's ack, err, and rdata are unchanged.
- Simultaneous f_req and m_req: data wins, except under forced fetch priority. The loser's stall stays high.
- mem_ack outside F_BUSY/M_BUSY is ignored.

Test Plan:
- Reset, then fetch f_addr=0x20 alone, memory acks on the first mem_req cycle with mem_rdata=80'h0123456789ABCDEF3030 → mem_req at N+1 with mem_addr=0x20 and mem_we=0; f_ack=1, f_err=0 and f_rdata equal to mem_rdata at N+2; f_stall high at N and N+1.
- Data write m_addr=0x100, m_wdata=64'hDEAD → mem_we=1 and mem_wdata=64'hDEAD held until mem_ack, which arrives after 3 cycles; m_ack one cycle later with m_rdata=0.
- f_req and m_req held continuously, each access zero-wait → grants are M,M,M,M,F,M,… (fetch forced after STARVE_MAX=4 losses); starve_cnt clears after the fetch grant.
- f_addr=1020 (1020+10 > 1024) → f_ack with f_err=1 one cycle after the request; mem_req never asserted. m_addr=64'hFFFF_FFFF_FFFF_FFFC (wraps) → m_err=1.
- mem_ack never returned → mem_req drops and m_ack with m_err=1 after 15 wait cycles; the next request is served normally.
- rst_n pulled low during M_BUSY → mem_req=0 immediately; no m_ack; state IDLE after rst_n release.
